// File: rtl/gf_pkg.sv
// Shared Galois-field / Chien-search constants and the Chien controller state type.
package gf_pkg;

  localparam int SYMB_WIDTH             = 8;
  localparam int ROOTS_PER_CYCLE__CHIEN = 4;
  localparam int CYCLES_NUM__CHIEN      = 64;
  localparam int CNTR_WIDTH__CHIEN      = 6;
  localparam int N_LEN                  = 255;
  localparam int T_LEN                  = 8;
  localparam int EVAL_LAT               = 1;

  // Width of a locator degree / root count (0..T_LEN)
  localparam int DEG_WIDTH = $clog2(T_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } chien_state_t;

endpackage

// File: rtl/rs_chien_err_collect.sv
// Packs up to R lane hits per cycle, in lane order, into the error-position list.
// Keeps a count that saturates at T_LEN and a sticky overflow flag.
module rs_chien_err_collect #(
  parameter int SYMB_WIDTH             = gf_pkg::SYMB_WIDTH,
  parameter int ROOTS_PER_CYCLE__CHIEN = gf_pkg::ROOTS_PER_CYCLE__CHIEN,
  parameter int N_LEN                  = gf_pkg::N_LEN,
  parameter int T_LEN                  = gf_pkg::T_LEN
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         clr,
  input  logic                                         en,
  input  logic [ROOTS_PER_CYCLE__CHIEN-1:0]            root_hit,
  input  logic [ROOTS_PER_CYCLE__CHIEN*SYMB_WIDTH-1:0] root_alpha,
  output logic [$clog2(T_LEN+1)-1:0]                   err_cnt,
  output logic [T_LEN*SYMB_WIDTH-1:0]                  err_pos,
  output logic [$clog2(T_LEN+1)-1:0]                   cnt_nxt,
  output logic                                         ovf_nxt
);

  localparam int R  = ROOTS_PER_CYCLE__CHIEN;
  localparam int DW = $clog2(T_LEN + 1);

  logic [SYMB_WIDTH-1:0] pos_q [T_LEN];
  logic [SYMB_WIDTH-1:0] pos_d [T_LEN];
  logic [DW-1:0]         cnt_q;
  logic [DW-1:0]         cnt_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic [SYMB_WIDTH-1:0] alpha;

  // Next list/count/overflow: lanes walked 0..R-1 so same-cycle hits land in lane order.
  // The write slot is chosen by comparing against every list index rather than indexing
  // with the count, which is wider than the list address.
  always_comb begin
    pos_d = pos_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    alpha = '0;
    if (clr) begin
      for (int unsigned j = 0; j < T_LEN; j++) pos_d[j] = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      for (int unsigned i = 0; i < R; i++) begin
        alpha = root_alpha[i*SYMB_WIDTH +: SYMB_WIDTH];
        if (root_hit[i] && (int'(alpha) < N_LEN)) begin
          if (cnt_d == DW'(T_LEN)) begin
            ovf_d = 1'b1;
          end else begin
            for (int unsigned j = 0; j < T_LEN; j++) begin
              if (cnt_d == DW'(j)) pos_d[j] = alpha;
            end
            cnt_d = cnt_d + 1'b1;
          end
        end
      end
    end
  end

  // List, count and overflow registers
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int unsigned j = 0; j < T_LEN; j++) pos_q[j] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Flatten the list onto the output bus, entry 0 in the low bits
  always_comb begin
    err_pos = '0;
    for (int unsigned j = 0; j < T_LEN; j++) err_pos[j*SYMB_WIDTH +: SYMB_WIDTH] = pos_q[j];
  end

  assign err_cnt = cnt_q;
  assign cnt_nxt = cnt_d;
  assign ovf_nxt = ovf_d;

endmodule

// File: rtl/rs_chien_ctrl.sv
// Chien search sequencer: accepts a locator job, drives the root sweep, collects
// evaluator hits and hands an error-position list to the Forney stage.
module rs_chien_ctrl #(
  parameter int SYMB_WIDTH             = gf_pkg::SYMB_WIDTH,
  parameter int ROOTS_PER_CYCLE__CHIEN = gf_pkg::ROOTS_PER_CYCLE__CHIEN,
  parameter int CYCLES_NUM__CHIEN      = gf_pkg::CYCLES_NUM__CHIEN,
  parameter int CNTR_WIDTH__CHIEN      = gf_pkg::CNTR_WIDTH__CHIEN,
  parameter int N_LEN                  = gf_pkg::N_LEN,
  parameter int T_LEN                  = gf_pkg::T_LEN,
  parameter int EVAL_LAT               = gf_pkg::EVAL_LAT
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         errloc_vld,
  output logic                                         errloc_rdy,
  input  logic [$clog2(T_LEN+1)-1:0]                   errloc_deg,
  output logic                                         sweep_vld,
  output logic [CNTR_WIDTH__CHIEN-1:0]                 sweep_cntr,
  input  logic [ROOTS_PER_CYCLE__CHIEN-1:0]            root_hit,
  input  logic [ROOTS_PER_CYCLE__CHIEN*SYMB_WIDTH-1:0] root_alpha,
  output logic                                         res_vld,
  input  logic                                         res_rdy,
  output logic [$clog2(T_LEN+1)-1:0]                   res_err_cnt,
  output logic [T_LEN*SYMB_WIDTH-1:0]                  res_err_pos,
  output logic                                         res_fail
);

  import gf_pkg::*;

  localparam int DEG_W = $clog2(T_LEN + 1);
  // Cycles since accept, covering the sweep plus the evaluator drain
  localparam int WIN_W = $clog2(CYCLES_NUM__CHIEN + EVAL_LAT + 1);

  chien_state_t     state;
  logic [DEG_W-1:0] deg_q;
  logic [WIN_W-1:0] win_cnt;
  logic             accept;
  logic             busy;
  logic             col_en;
  logic [DEG_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             fail_d;

  assign accept = (state == IDLE) && errloc_vld;
  assign busy   = (state == SWEEP) || (state == DRAIN);
  // Hits for sweep cycle k arrive EVAL_LAT cycles later, so the window trails the sweep
  assign col_en = busy && (win_cnt >= WIN_W'(EVAL_LAT))
                       && (win_cnt < WIN_W'(CYCLES_NUM__CHIEN + EVAL_LAT));
  // Judged on the collector's next values so the final hit counts on the DONE edge
  assign fail_d = ovf_nxt || (cnt_nxt != deg_q);

  rs_chien_err_collect #(
    .SYMB_WIDTH             (SYMB_WIDTH),
    .ROOTS_PER_CYCLE__CHIEN (ROOTS_PER_CYCLE__CHIEN),
    .N_LEN                  (N_LEN),
    .T_LEN                  (T_LEN)
  ) u_collect (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .clr        (accept),
    .en         (col_en),
    .root_hit   (root_hit),
    .root_alpha (root_alpha),
    .err_cnt    (res_err_cnt),
    .err_pos    (res_err_pos),
    .cnt_nxt    (cnt_nxt),
    .ovf_nxt    (ovf_nxt)
  );

  // Job sequencing FSM with registered handshake and sweep outputs
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state      <= IDLE;
      errloc_rdy <= 1'b1;
      sweep_vld  <= 1'b0;
      sweep_cntr <= '0;
      res_vld    <= 1'b0;
      res_fail   <= 1'b0;
      deg_q      <= '0;
      win_cnt    <= '0;
    end else begin
      sweep_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (errloc_vld) begin
            deg_q      <= errloc_deg;
            state      <= SWEEP;
            errloc_rdy <= 1'b0;
            sweep_vld  <= 1'b1;
            sweep_cntr <= '0;
            win_cnt    <= '0;
          end
        end
        SWEEP: begin
          win_cnt <= win_cnt + 1'b1;
          if (sweep_cntr == CNTR_WIDTH__CHIEN'(CYCLES_NUM__CHIEN - 1)) begin
            sweep_cntr <= '0;
            if (EVAL_LAT == 0) begin
              state    <= DONE;
              res_vld  <= 1'b1;
              res_fail <= fail_d;
            end else begin
              state <= DRAIN;
            end
          end else begin
            sweep_cntr <= sweep_cntr + 1'b1;
          end
        end
        DRAIN: begin
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == WIN_W'(CYCLES_NUM__CHIEN + EVAL_LAT - 1)) begin
            state    <= DONE;
            res_vld  <= 1'b1;
            res_fail <= fail_d;
          end
        end
        DONE: begin
          if (res_rdy) begin
            state      <= IDLE;
            res_vld    <= 1'b0;
            res_fail   <= 1'b0;
            errloc_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
